dom_rand_source: RTL and testbench
==================================

Name: dom_rand_source

Overview:
- Fresh-randomness source directly upstream of the first-order DOM-indep AND gadgets. It drives their random-share input (port_r).
- Holds a 32-bit maximal-length Fibonacci LFSR with a seed-load handshake and a warm-up phase.
- Delivers RAND_W fresh bits per accepted transfer using a valid/ready handshake.
- Guarantees that no randomness word is ever presented to a gadget twice.

Parameters:
- RAND_W, 1, bits delivered per transfer (legal 1..16); one bit per first-order gadget instance.
- WARMUP_CYCLES, 64, LFSR steps (clock cycles) discarded after each seed load (legal >= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- seed_i  input  32  seed value.
- seed_valid_i  input  1  seed offered.
- seed_ready_o  output  1  seed can be accepted.
- rand_o  output  RAND_W  fresh random bits (to gadget port_r).
- rand_valid_o  output  1  rand_o is fresh and unused.
- rand_ready_i  input  1  consumer takes rand_o this cycle.
- busy_o  output  1  high in WARMUP.
- err_o  output  1  health-check failure (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=UNSEEDED, lfsr=0, counter=0, seed_ready_o=1, rand_valid_o=0, busy_o=0, err_o=0. rand_o=0 follows from lfsr=0.
- LFSR step, polynomial x^32+x^22+x^2+x+1:
  - fb = s[31]^s[21]^s[1]^s[0]
  - s <= {s[30:0], fb}
- One "advance" applies RAND_W steps within a single cycle.
- rand_o = s[RAND_W-1:0], combinational from the register.
- Seed acceptance:
  - Occurs when seed_valid_i && seed_ready_o && seed_i != 0.
  - Loads s=seed_i, counter=WARMUP_CYCLES-1, state=WARMUP.
  - A zero seed is never accepted: the state is unchanged and seed_ready_o stays high.
- States:
  - UNSEEDED: seed_ready_o=1, rand_valid_o=0. Goes to WARMUP on acceptance.
  - WARMUP: seed_ready_o=0, busy_o=1, rand_valid_o=0. Advances every cycle; the counter decrements. When the counter is 0, the advance happens and the next state is RUN. WARMUP therefore lasts exactly WARMUP_CYCLES cycles.
  - RUN: rand_valid_o=1, seed_ready_o=1.
    - rand_valid_o && rand_ready_i advances once, so the next word is valid the following cycle.
    - There is no advance without rand_ready_i; rand_o is held stable.
- Reseed in RUN: acceptance takes priority over a simultaneous consume. The transfer in that cycle still counts for the consumer, the seed is loaded (no advance), and rand_valid_o drops next cycle.
- rand_ready_i outside RUN is ignored.
- rst mid-WARMUP or mid-RUN: returns to the reset values on the next edge. A new seed is required.
- Throughput: one word per cycle in RUN, with zero-bubble back-to-back consumption.

Optional Feature:
- Macro: DOM_RAND_HEALTH_CHECK_EN.
- With the macro defined:
  - A 6-bit counter counts consecutive consumed words equal to the previous consumed word.
  - At 40 repeats, err_o is set (sticky), rand_valid_o is forced 0 and the state is held in RUN.
  - Only rst or an accepted reseed clears err_o and the counter.
  - 40 repeats are unreachable for a healthy maximal LFSR, so reaching that count flags a stuck state register.
- Without the macro: err_o is tied to 0 and no counter is built.

Decomposition:
- Package dom_rand_pkg holds:
  - LFSR_W=32
  - tap positions {31,21,1,0}
  - state enum {UNSEEDED, WARMUP, RUN}
  - HC_LIMIT=40
- Sub-module dom_lfsr_step: combinational RAND_W-step advance function (input s, output s_next), instantiated once.

Test Plan:
- Reset with seed_valid_i=1 and seed 0x1 held: during rst, seed_ready_o=1, rand_valid_o=0, err_o=0. No load occurs while rst is high.
- RAND_W=1, WARMUP_CYCLES=1, seed 0x00000001 accepted at cycle 0:
  - cycle 1 WARMUP (busy_o=1)
  - cycle 2 RUN, s=0x3, rand_o=1
  - consume: s=0x6, rand_o=0
  - consume: s=0xD, rand_o=1
- Default WARMUP_CYCLES=64, any nonzero seed accepted at cycle 0: rand_valid_o rises exactly at cycle 65. rand_ready_i=0 for 10 cycles leaves rand_o unchanged.
- Seed 0x0 offered in UNSEEDED: no state change, seed_ready_o stays 1. Then seed 0xDEADBEEF is accepted and WARMUP starts.
- In RUN, seed_valid_i and rand_ready_i both high in one cycle: the word is consumed, the seed is loaded, and the next cycle has rand_valid_o=0, busy_o=1.
- With DOM_RAND_HEALTH_CHECK_EN, force lfsr to a stuck value and consume 41 words: err_o=1 after the 41st, then rand_valid_o=0. A reseed clears err_o. Without the macro, err_o stays 0.

Source files
------------

// File: rtl/dom_rand_pkg.sv
// Shared constants and types for the DOM fresh-randomness source.
package dom_rand_pkg;

    localparam int LFSR_W   = 32;
    localparam int TAP_A    = 31;
    localparam int TAP_B    = 21;
    localparam int TAP_C    = 1;
    localparam int TAP_D    = 0;
    localparam int HC_LIMIT = 40;
    localparam int HC_W     = 6;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

endpackage

// File: rtl/dom_lfsr_step.sv
// Combinational advance of the Fibonacci LFSR by RAND_W steps in one cycle.
module dom_lfsr_step
    import dom_rand_pkg::*;
#(
    parameter int RAND_W = 1
) (
    input  logic [LFSR_W-1:0] s_i,
    output logic [LFSR_W-1:0] s_next_o
);

    logic [LFSR_W-1:0] s_w;

    always_comb begin
        s_w = s_i;
        for (int i = 0; i < RAND_W; i++) begin
            s_w = {s_w[LFSR_W-2:0], s_w[TAP_A] ^ s_w[TAP_B] ^ s_w[TAP_C] ^ s_w[TAP_D]};
        end
        s_next_o = s_w;
    end

endmodule

// File: rtl/dom_rand_source.sv
// Seeded LFSR randomness source feeding DOM-indep AND gadgets (port_r).
// Optional stuck-state health check: define DOM_RAND_HEALTH_CHECK_EN.
module dom_rand_source
    import dom_rand_pkg::*;
#(
    parameter int RAND_W        = 1,
    parameter int WARMUP_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       seed_i,
    input  logic              seed_valid_i,
    output logic              seed_ready_o,
    output logic [RAND_W-1:0] rand_o,
    output logic              rand_valid_o,
    input  logic              rand_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    // Counter only has to hold WARMUP_CYCLES-1.
    localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hc_err;
    logic              seed_acc, consume;

    dom_lfsr_step #(.RAND_W(RAND_W)) u_step (
        .s_i      (lfsr_q),
        .s_next_o (lfsr_adv)
    );

    assign rand_o       = lfsr_q[RAND_W-1:0];
    assign seed_ready_o = (state_q != ST_WARMUP);
    assign busy_o       = (state_q == ST_WARMUP);
    assign rand_valid_o = (state_q == ST_RUN) && !hc_err;
    assign err_o        = hc_err;
    assign seed_acc     = seed_valid_i && seed_ready_o && (seed_i != '0);
    assign consume      = rand_valid_o && rand_ready_i;

    // A reseed wins over a same-cycle consume: the word still goes out, but the seed replaces the advance.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        if (seed_acc) begin
            lfsr_d  = seed_i;
            cnt_d   = CNT_INIT;
            state_d = ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    lfsr_d = lfsr_adv;
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_RUN: if (consume) lfsr_d = lfsr_adv;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNSEEDED;
            lfsr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DOM_RAND_HEALTH_CHECK_EN
    logic [RAND_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [HC_W-1:0]   hc_cnt_q, hc_cnt_d;
    logic              err_q, err_d;

    // A healthy maximal LFSR never repeats a word HC_LIMIT times in a row.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        hc_cnt_d   = hc_cnt_q;
        err_d      = err_q;
        if (seed_acc) begin
            prev_vld_d = 1'b0;
            hc_cnt_d   = '0;
            err_d      = 1'b0;
        end else if (consume) begin
            prev_d     = rand_o;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (rand_o == prev_q)) begin
                hc_cnt_d = hc_cnt_q + 1'b1;
                if (hc_cnt_q == HC_W'(HC_LIMIT - 1)) err_d = 1'b1;
            end else begin
                hc_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            hc_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            hc_cnt_q   <= hc_cnt_d;
            err_q      <= err_d;
        end
    end

    assign hc_err = err_q;
`else
    assign hc_err = 1'b0;
`endif

endmodule

// File: tb/tb_dom_rand_source.sv
// Bench for dom_rand_source: directed table on a 1-bit/1-cycle-warmup instance,
// model-checked random traffic on a 4-bit/default-warmup instance.
module tb_dom_rand_source;

    localparam int BW  = 4;
    localparam int BWC = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_seed, b_seed;
    logic        a_sv, b_sv, a_rr, b_rr;
    logic        a_ready, a_valid, a_busy, a_err;
    logic        b_ready, b_valid, b_busy, b_err;
    logic [0:0]  a_rand;
    logic [BW-1:0] b_rand;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dom_rand_source #(.RAND_W(1), .WARMUP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .seed_i(a_seed), .seed_valid_i(a_sv), .seed_ready_o(a_ready),
        .rand_o(a_rand), .rand_valid_o(a_valid), .rand_ready_i(a_rr), .busy_o(a_busy), .err_o(a_err)
    );

    dom_rand_source #(.RAND_W(BW)) dut_b (
        .clk(clk), .rst(rst), .seed_i(b_seed), .seed_valid_i(b_sv), .seed_ready_o(b_ready),
        .rand_o(b_rand), .rand_valid_o(b_valid), .rand_ready_i(b_rr), .busy_o(b_busy), .err_o(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: polynomial x^32+x^22+x^2+x+1, n shifts.
    function automatic logic [31:0] adv(input logic [31:0] s, input int n);
        logic [31:0] r = s;
        for (int i = 0; i < n; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
        return r;
    endfunction

    // Behavioural model of instance b: phase 0=unseeded 1=warm-up 2=run.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_s     = '0;

    task automatic b_cycle(input logic sv, input logic [31:0] seed, input logic rr);
        logic [7:0] exp;
        @(negedge clk);
        exp = {(m_phase != 1), (m_phase == 2), (m_phase == 1), 1'b0, m_s[BW-1:0]};
        chk("b_outputs", {24'd0, b_ready, b_valid, b_busy, b_err, b_rand}, {24'd0, exp});
        b_sv = sv; b_seed = seed; b_rr = rr;
        if (sv && m_phase != 1 && seed != 0) begin
            m_s = seed; m_left = BWC; m_phase = 1;
        end else if (m_phase == 1) begin
            m_s = adv(m_s, BW);
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (m_phase == 2 && rr) begin
            m_s = adv(m_s, BW);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic        sv;
        logic [31:0] seed;
        logic        rr;
        logic [4:0]  exp;   // {seed_ready, rand_valid, busy, err, rand}
    } vec_t;

    vec_t tbl [11];

    initial begin
        int rise;
        logic [BW-1:0] held;

        tbl[0]  = '{1'b0, 1'b1, 32'h0, 1'b0, 5'b10000};  // zero seed refused
        tbl[1]  = '{1'b0, 1'b1, 32'h1, 1'b0, 5'b10000};
        tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 5'b00101};  // warm-up, s=1
        tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 5'b11001};  // s=3
        tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 5'b11000};  // s=6
        tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 5'b11000};  // s=6 held
        tbl[6]  = '{1'b0, 1'b1, 32'h1, 1'b1, 5'b11001};  // s=D, reseed + consume
        tbl[7]  = '{1'b0, 1'b1, 32'h5, 1'b0, 5'b00101};  // seed ignored in warm-up
        tbl[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 5'b11001};  // s=3, reset asserted
        tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 5'b10000};
        tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 5'b10000};

        rst = 1'b1;
        a_sv = 1'b1; a_seed = 32'h1; a_rr = 1'b0;
        b_sv = 1'b1; b_seed = 32'h1; b_rr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_a", {a_ready, a_valid, a_busy, a_err, a_rand}, 5'b10000);
            chk("reset_b", {b_ready, b_valid, b_busy, b_err, b_rand}, {4'b1000, {BW{1'b0}}});
        end
        rst = 1'b0; a_sv = 1'b0; b_sv = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("table_a[%0d]", i), {a_ready, a_valid, a_busy, a_err, a_rand}, tbl[i].exp);
            rst = tbl[i].rst; a_sv = tbl[i].sv; a_seed = tbl[i].seed; a_rr = tbl[i].rr;
        end

        b_cycle(1'b1, 32'h0, 1'b0);
        b_cycle(1'b1, 32'hDEADBEEF, 1'b1);
        rise = -1;
        for (int k = 1; k <= 70; k++) begin
            b_cycle(1'b0, 32'h0, 1'b0);
            if (b_valid && rise < 0) rise = k;
        end
        chk("valid_rise_cycle", rise, 65);
        held = b_rand;
        for (int k = 0; k < 10; k++) b_cycle(1'b0, 32'h0, 1'b0);
        chk("hold_without_ready", {28'd0, b_rand}, {28'd0, held});

        for (int k = 0; k < 600; k++) begin
            b_cycle($urandom_range(0, 59) == 0,
                    ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                    $urandom_range(0, 9) < 7);
        end

        for (int k = 0; k < 100 && m_phase != 2; k++) b_cycle(1'b0, 32'h0, 1'b0);
        b_cycle(1'b1, 32'h12345678, 1'b1);
        b_cycle(1'b0, 32'h0, 1'b0);
        chk("reseed_priority", {30'd0, b_valid, b_busy}, 32'b01);
        chk("reseed_loaded", {28'd0, b_rand}, 32'h8);

`ifdef DOM_RAND_HEALTH_CHECK_EN
        for (int k = 0; k < 100 && m_phase != 2; k++) b_cycle(1'b0, 32'h0, 1'b0);
        force dut_b.lfsr_q = 32'hA5A5A5A5;
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            b_rr = 1'b1;
        end
        @(negedge clk);
        b_rr = 1'b0;
        chk("hc_err_set", {30'd0, b_err, b_valid}, 32'b10);
        release dut_b.lfsr_q;
        b_sv = 1'b1; b_seed = 32'h1;
        @(negedge clk);
        b_sv = 1'b0;
        chk("hc_err_cleared", {31'd0, b_err}, 32'd0);
`else
        chk("err_tied_low", {31'd0, b_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
